// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and bypass-select generation for the five-stage pipeline.
// Keeps shadow copies of the E, M and W stages and compares them against the
// instruction currently in D.
// Optional feature: define HAZ_STALL_CNT_EN to add the saturating stall_count output.
module hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_ctrl,
   output logic        PCfreeze,
   output logic        setNOP,
   output logic [31:0] D_FMUX1_slt,
   output logic [31:0] D_FMUX2_slt,
   output logic [31:0] E_FMUX1_slt,
   output logic [31:0] E_FMUX2_slt,
   output logic [31:0] M_FUMX_slt
`ifdef HAZ_STALL_CNT_EN
   ,
   output logic [31:0] stall_count
`endif
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   // Unused sources are stored as $0 so they can never match a producer.
   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dst;
      logic       is_mem;
      logic       is_sw;
      logic [1:0] tnew;
   } e_ent_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rt;
      logic [4:0] dst;
      logic       is_mem;
      logic       is_sw;
      logic [1:0] tnew;
   } m_ent_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] dst;
      logic       is_mem;
   } w_ent_t;

   // Decode the D-stage word into a shadow entry; unknown words become a nop.
   function automatic e_ent_t decode(input logic [31:0] ins);
      e_ent_t ent;
      ent = '0;
      case (ins[31:26])
         OP_RTYPE: begin
            if ((ins[10:6] == 5'd0) && ((ins[5:0] == FN_ADDU) || (ins[5:0] == FN_SUBU))) begin
               ent.valid = 1'b1; ent.rs = ins[25:21]; ent.rt = ins[20:16];
               ent.dst = ins[15:11]; ent.tnew = 2'd1;
            end else if ((ins[10:6] == 5'd0) && (ins[5:0] == FN_JR)) begin
               ent.valid = 1'b1; ent.rs = ins[25:21];
            end else begin
               ent = '0;
            end
         end
         OP_ORI:  begin ent.valid = 1'b1; ent.rs = ins[25:21]; ent.dst = ins[20:16]; ent.tnew = 2'd1; end
         OP_LUI:  begin ent.valid = 1'b1; ent.dst = ins[20:16]; ent.tnew = 2'd1; end
         OP_LW:   begin ent.valid = 1'b1; ent.rs = ins[25:21]; ent.dst = ins[20:16];
                        ent.is_mem = 1'b1; ent.tnew = 2'd2; end
         OP_SW:   begin ent.valid = 1'b1; ent.rs = ins[25:21]; ent.rt = ins[20:16]; ent.is_sw = 1'b1; end
         OP_BEQ:  begin ent.valid = 1'b1; ent.rs = ins[25:21]; ent.rt = ins[20:16]; end
         OP_J:    begin ent.valid = 1'b1; end
         OP_JAL:  begin ent.valid = 1'b1; ent.dst = 5'd31; ent.tnew = 2'd1; end
         default: begin ent = '0; end
      endcase
      // A $0 destination produces nothing anyone can consume.
      if (ent.dst == 5'd0) begin
         ent.tnew = 2'd0; ent.is_mem = 1'b0;
      end else begin
         ent.tnew = ent.tnew;
      end
      return ent;
   endfunction

   // Cycles from D until each source is consumed, packed as {tuse_rs, tuse_rt}.
   function automatic logic [3:0] tuse(input logic [31:0] ins);
      case (ins[31:26])
         OP_BEQ:   tuse = {2'd0, 2'd0};
         OP_SW:    tuse = {2'd1, 2'd2};
         OP_RTYPE: tuse = (ins[5:0] == FN_JR) ? {2'd0, 2'd1} : {2'd1, 2'd1};
         default:  tuse = {2'd1, 2'd1};
      endcase
   endfunction

   // Source s must wait if an in-flight producer is not ready by Tuse.
   function automatic logic needs_stall(input logic [4:0] s, input logic [1:0] tu,
                                        input e_ent_t e, input m_ent_t m);
      needs_stall = (s != 5'd0) &&
                    ((e.valid && (e.dst == s) && (e.tnew > tu)) ||
                     (m.valid && (m.dst == s) && (m.tnew > tu)));
   endfunction

   // W-only bypass: ALU result or load data at the end of the pipe.
   function automatic logic [1:0] w_sel(input logic [4:0] s, input w_ent_t w);
      if ((s != 5'd0) && w.valid && (w.dst == s)) w_sel = w.is_mem ? 2'd3 : 2'd2;
      else                                        w_sel = 2'd0;
   endfunction

   // Bypass chain: ready ALU result in M (younger) beats anything in W.
   function automatic logic [1:0] fwd_sel(input logic [4:0] s, input m_ent_t m, input w_ent_t w);
      if ((s != 5'd0) && m.valid && (m.dst == s) && (m.tnew == 2'd0) && !m.is_mem) fwd_sel = 2'd1;
      else                                                                         fwd_sel = w_sel(s, w);
   endfunction

   e_ent_t e_r, d_ent_s;
   m_ent_t m_r;
   w_ent_t w_r;
   logic [3:0] tuse_s;
   logic       stall_s;

   // Decode D and evaluate the stall condition.
   always_comb begin
      d_ent_s = decode(instr_ctrl);
      tuse_s  = tuse(instr_ctrl);
      stall_s = needs_stall(d_ent_s.rs, tuse_s[3:2], e_r, m_r) ||
                needs_stall(d_ent_s.rt, tuse_s[1:0], e_r, m_r);
   end

   // Advance the shadow pipeline; a stall injects a bubble into E.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_r <= '0;
         m_r <= '0;
         w_r <= '0;
      end else begin
         w_r <= '{valid: m_r.valid, dst: m_r.dst, is_mem: m_r.is_mem};
         m_r <= '{valid: e_r.valid, rt: e_r.rt, dst: e_r.dst, is_mem: e_r.is_mem,
                  is_sw: e_r.is_sw, tnew: (e_r.tnew == 2'd0) ? 2'd0 : e_r.tnew - 2'd1};
         e_r <= stall_s ? '0 : d_ent_s;
      end
   end

   // Drive stall and forwarding selects straight to the datapath.
   always_comb begin
      PCfreeze    = stall_s;
      setNOP      = stall_s;
      D_FMUX1_slt = {30'd0, fwd_sel(d_ent_s.rs, m_r, w_r)};
      D_FMUX2_slt = {30'd0, fwd_sel(d_ent_s.rt, m_r, w_r)};
      E_FMUX1_slt = {30'd0, fwd_sel(e_r.rs, m_r, w_r)};
      E_FMUX2_slt = {30'd0, fwd_sel(e_r.rt, m_r, w_r)};
      if (m_r.valid && m_r.is_sw) M_FUMX_slt = {30'd0, w_sel(m_r.rt, w_r)};
      else                        M_FUMX_slt = 32'd0;
   end

`ifdef HAZ_STALL_CNT_EN
   logic [31:0] stall_cnt_r;

   // Count stalled cycles, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset)                                       stall_cnt_r <= 32'd0;
      else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) stall_cnt_r <= stall_cnt_r + 32'd1;
      else                                             stall_cnt_r <= stall_cnt_r;
   end

   assign stall_count = stall_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instr_ctrl = 32'd0;
   logic        PCfreeze, setNOP;
   logic [31:0] D_FMUX1_slt, D_FMUX2_slt, E_FMUX1_slt, E_FMUX2_slt, M_FUMX_slt;
`ifdef HAZ_STALL_CNT_EN
   logic [31:0] stall_count;
`endif
   int n_cmp = 0;
   int n_err = 0;

   localparam logic [31:0] LW_1_0     = 32'h8C01_0000; // lw   $1,0($0)
   localparam logic [31:0] LW_5_0     = 32'h8C05_0000; // lw   $5,0($0)
   localparam logic [31:0] SW_5_4_6   = 32'hACC5_0004; // sw   $5,4($6)
   localparam logic [31:0] ADDU_2_1_3 = 32'h0023_1021; // addu $2,$1,$3
   localparam logic [31:0] ADDU_1_2_3 = 32'h0043_0821; // addu $1,$2,$3
   localparam logic [31:0] ADDU_0_2_3 = 32'h0043_0021; // addu $0,$2,$3
   localparam logic [31:0] ADDU_4_0_0 = 32'h0000_2021; // addu $4,$0,$0
   localparam logic [31:0] BEQ_1_4    = 32'h1024_0000; // beq  $1,$4
   localparam logic [31:0] BEQ_1_0    = 32'h1020_0000; // beq  $1,$0
   localparam logic [31:0] JAL_0      = 32'h0C00_0000; // jal  0
   localparam logic [31:0] JR_31      = 32'h03E0_0008; // jr   $31

   hazard_ctrl dut (
      .clk(clk), .reset(reset), .instr_ctrl(instr_ctrl),
      .PCfreeze(PCfreeze), .setNOP(setNOP),
      .D_FMUX1_slt(D_FMUX1_slt), .D_FMUX2_slt(D_FMUX2_slt),
      .E_FMUX1_slt(E_FMUX1_slt), .E_FMUX2_slt(E_FMUX2_slt),
      .M_FUMX_slt(M_FUMX_slt)
`ifdef HAZ_STALL_CNT_EN
      , .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   // Present one word in D for one cycle; sample on the falling edge.
   task automatic cyc(input logic [31:0] ins);
      @(posedge clk); #1; instr_ctrl = ins;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1; reset = 1'b1; instr_ctrl = 32'd0;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] sel_or;
      do_reset();
      n_cmp++; if (PCfreeze !== 1'b0) begin n_err++; $display("FAIL reset_pcfreeze got %0d want 0", PCfreeze); end
      n_cmp++; if (setNOP !== 1'b0) begin n_err++; $display("FAIL reset_setnop got %0d want 0", setNOP); end
      sel_or = D_FMUX1_slt | D_FMUX2_slt | E_FMUX1_slt | E_FMUX2_slt | M_FUMX_slt;
      n_cmp++; if (sel_or !== 32'd0) begin n_err++; $display("FAIL reset_selects got %0h want 0", sel_or); end
`ifdef HAZ_STALL_CNT_EN
      n_cmp++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", stall_count); end
`endif
   endtask

   task automatic test_lw_alu();
      do_reset();
      cyc(LW_1_0);
      n_cmp++; if (PCfreeze !== 1'b0) begin n_err++; $display("FAIL lw_alu_c0 got %0d want 0", PCfreeze); end
      cyc(ADDU_2_1_3);
      n_cmp++; if (PCfreeze !== 1'b1) begin n_err++; $display("FAIL lw_alu_stall got %0d want 1", PCfreeze); end
      n_cmp++; if (setNOP !== 1'b1) begin n_err++; $display("FAIL lw_alu_nop got %0d want 1", setNOP); end
      cyc(ADDU_2_1_3);
      n_cmp++; if (PCfreeze !== 1'b0) begin n_err++; $display("FAIL lw_alu_release got %0d want 0", PCfreeze); end
      cyc(32'd0);
      n_cmp++; if (E_FMUX1_slt !== 32'd3) begin n_err++; $display("FAIL lw_alu_e1 got %0d want 3", E_FMUX1_slt); end
      n_cmp++; if (E_FMUX2_slt !== 32'd0) begin n_err++; $display("FAIL lw_alu_e2 got %0d want 0", E_FMUX2_slt); end
   endtask

   task automatic test_alu_beq();
      do_reset();
      cyc(ADDU_1_2_3);
      cyc(BEQ_1_4);
      n_cmp++; if (PCfreeze !== 1'b1) begin n_err++; $display("FAIL alu_beq_stall got %0d want 1", PCfreeze); end
      cyc(BEQ_1_4);
      n_cmp++; if (PCfreeze !== 1'b0) begin n_err++; $display("FAIL alu_beq_release got %0d want 0", PCfreeze); end
      n_cmp++; if (D_FMUX1_slt !== 32'd1) begin n_err++; $display("FAIL alu_beq_d1 got %0d want 1", D_FMUX1_slt); end
      n_cmp++; if (D_FMUX2_slt !== 32'd0) begin n_err++; $display("FAIL alu_beq_d2 got %0d want 0", D_FMUX2_slt); end
   endtask

   task automatic test_lw_beq();
      do_reset();
      cyc(LW_1_0);
      cyc(BEQ_1_0);
      n_cmp++; if (PCfreeze !== 1'b1) begin n_err++; $display("FAIL lw_beq_stall1 got %0d want 1", PCfreeze); end
      cyc(BEQ_1_0);
      n_cmp++; if (PCfreeze !== 1'b1) begin n_err++; $display("FAIL lw_beq_stall2 got %0d want 1", PCfreeze); end
      cyc(BEQ_1_0);
      n_cmp++; if (PCfreeze !== 1'b0) begin n_err++; $display("FAIL lw_beq_release got %0d want 0", PCfreeze); end
      n_cmp++; if (D_FMUX1_slt !== 32'd3) begin n_err++; $display("FAIL lw_beq_d1 got %0d want 3", D_FMUX1_slt); end
`ifdef HAZ_STALL_CNT_EN
      n_cmp++; if (stall_count !== 32'd2) begin n_err++; $display("FAIL lw_beq_count got %0d want 2", stall_count); end
`endif
   endtask

   task automatic test_zero_dst();
      logic [31:0] sel_or;
      do_reset();
      cyc(ADDU_0_2_3);
      n_cmp++; if (PCfreeze !== 1'b0) begin n_err++; $display("FAIL zero_c0 got %0d want 0", PCfreeze); end
      cyc(ADDU_4_0_0);
      n_cmp++; if (PCfreeze !== 1'b0) begin n_err++; $display("FAIL zero_c1 got %0d want 0", PCfreeze); end
      sel_or = D_FMUX1_slt | D_FMUX2_slt | E_FMUX1_slt | E_FMUX2_slt | M_FUMX_slt;
      n_cmp++; if (sel_or !== 32'd0) begin n_err++; $display("FAIL zero_sel1 got %0h want 0", sel_or); end
      cyc(32'd0);
      sel_or = D_FMUX1_slt | D_FMUX2_slt | E_FMUX1_slt | E_FMUX2_slt | M_FUMX_slt;
      n_cmp++; if (sel_or !== 32'd0) begin n_err++; $display("FAIL zero_sel2 got %0h want 0", sel_or); end
   endtask

   task automatic test_lw_sw();
      do_reset();
      cyc(LW_5_0);
      cyc(SW_5_4_6);
      n_cmp++; if (PCfreeze !== 1'b0) begin n_err++; $display("FAIL lw_sw_nostall got %0d want 0", PCfreeze); end
      cyc(32'd0);
      n_cmp++; if (E_FMUX2_slt !== 32'd0) begin n_err++; $display("FAIL lw_sw_e2 got %0d want 0", E_FMUX2_slt); end
      cyc(32'd0);
      n_cmp++; if (M_FUMX_slt !== 32'd3) begin n_err++; $display("FAIL lw_sw_m got %0d want 3", M_FUMX_slt); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      cyc(LW_1_0);
      cyc(ADDU_1_2_3);
      cyc(32'd0);
      cyc(BEQ_1_0);
      n_cmp++; if (PCfreeze !== 1'b0) begin n_err++; $display("FAIL b2b_nostall got %0d want 0", PCfreeze); end
      n_cmp++; if (D_FMUX1_slt !== 32'd1) begin n_err++; $display("FAIL b2b_m_priority got %0d want 1", D_FMUX1_slt); end
   endtask

   task automatic test_jal_jr();
      do_reset();
      cyc(JAL_0);
      cyc(JR_31);
      n_cmp++; if (PCfreeze !== 1'b1) begin n_err++; $display("FAIL jal_jr_stall got %0d want 1", PCfreeze); end
      cyc(JR_31);
      n_cmp++; if (PCfreeze !== 1'b0) begin n_err++; $display("FAIL jal_jr_release got %0d want 0", PCfreeze); end
      n_cmp++; if (D_FMUX1_slt !== 32'd1) begin n_err++; $display("FAIL jal_jr_d1 got %0d want 1", D_FMUX1_slt); end
   endtask

   task automatic test_reset_in_stall();
      logic [31:0] sel_or;
      do_reset();
      cyc(LW_1_0);
      cyc(BEQ_1_0);
      n_cmp++; if (PCfreeze !== 1'b1) begin n_err++; $display("FAIL rst_stall_pre got %0d want 1", PCfreeze); end
      reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (PCfreeze !== 1'b0) begin n_err++; $display("FAIL rst_stall_after got %0d want 0", PCfreeze); end
      sel_or = D_FMUX1_slt | D_FMUX2_slt | E_FMUX1_slt | E_FMUX2_slt | M_FUMX_slt;
      n_cmp++; if (sel_or !== 32'd0) begin n_err++; $display("FAIL rst_stall_sel got %0h want 0", sel_or); end
`ifdef HAZ_STALL_CNT_EN
      n_cmp++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL rst_stall_count got %0d want 0", stall_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_lw_alu();
      test_alu_beq();
      test_lw_beq();
      test_zero_dst();
      test_lw_sw();
      test_back_to_back();
      test_jal_jr();
      test_reset_in_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
